// File: rtl/lupa_spi_slave_regs.sv
// LUPA300 3-wire configuration SPI responder: oversampled frame decoder plus register bank.
// Optional LUPA_SHADOW_EN: writes are staged in a shadow bank and applied on the Frame_Valid falling edge.
module lupa_spi_slave_regs #(
  parameter int unsigned         NREG     = 16,
  parameter int unsigned         DW       = 8,
  parameter int unsigned         AW       = 7,
  parameter logic [NREG*DW-1:0]  DEFAULTS = '0
) (
  input  logic               iCLOCK_80,
  input  logic               RST_N,
  input  logic               SPI_EN,
  input  logic               SPI_CLK,
  input  logic               SPI_DAT,
  input  logic               Frame_Valid,
  output logic [NREG*DW-1:0] regs_flat,
  output logic               wr_stb,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               frame_err,
  output logic [15:0]        wr_count
);

  localparam int unsigned FW     = 1 + AW + DW;
  localparam logic [4:0]  FW_LEN = 5'(FW);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK, S_COMMIT} state_t;

  state_t         state;
  logic [FW-1:0]  sr;
  logic [4:0]     bitcnt;
  logic           start_pend;

  logic en_s1, en_s2, en_s3;
  logic ck_s1, ck_s2, ck_s3;
  logic dt_s1, dt_s2;
  logic fv_s1, fv_s2;

  always_ff @(posedge iCLOCK_80 or negedge RST_N) begin
    if (!RST_N) begin
      en_s1 <= 1'b1; en_s2 <= 1'b1; en_s3 <= 1'b1;
      ck_s1 <= 1'b0; ck_s2 <= 1'b0; ck_s3 <= 1'b0;
      dt_s1 <= 1'b0; dt_s2 <= 1'b0;
      fv_s1 <= 1'b0; fv_s2 <= 1'b0;
    end else begin
      en_s1 <= SPI_EN;      en_s2 <= en_s1; en_s3 <= en_s2;
      ck_s1 <= SPI_CLK;     ck_s2 <= ck_s1; ck_s3 <= ck_s2;
      dt_s1 <= SPI_DAT;     dt_s2 <= dt_s1;
      fv_s1 <= Frame_Valid; fv_s2 <= fv_s1;
    end
  end

  logic          en_fall, en_rise, clk_rise, restart;
  logic          f_w, len_ok, addr_ok;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_data;
  logic [NREG-1:0] hit;

  always_comb begin
    en_fall  = !en_s2 && en_s3;
    en_rise  = en_s2 && !en_s3;
    clk_rise = ck_s2 && !ck_s3;
    restart  = start_pend || en_fall;
    f_w      = sr[FW-1];
    f_addr   = sr[FW-2 -: AW];
    f_data   = sr[DW-1:0];
    len_ok   = (bitcnt == FW_LEN);
    addr_ok  = (32'(f_addr) < NREG);
    hit      = '0;
    if (state == S_COMMIT) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (AW'(i) == f_addr) hit[i] = 1'b1;
      end
    end
  end

  // An SPI_EN fall arriving during CHECK/COMMIT is held in start_pend so the next frame starts directly.
  always_ff @(posedge iCLOCK_80 or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      sr         <= '0;
      bitcnt     <= '0;
      start_pend <= 1'b0;
      wr_stb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_err  <= 1'b0;
      wr_count   <= '0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en_fall) begin
            sr     <= '0;
            bitcnt <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (en_rise) begin
            state      <= S_CHECK;
            start_pend <= 1'b0;
          end else if (clk_rise && !en_s2) begin
            sr <= {sr[FW-2:0], dt_s2};
            if (bitcnt != 5'd31) bitcnt <= bitcnt + 5'd1;
          end
        end
        S_CHECK: begin
          if (len_ok && f_w && addr_ok) begin
            state      <= S_COMMIT;
            start_pend <= restart;
          end else begin
            if (!(len_ok && !f_w)) frame_err <= 1'b1;
            start_pend <= 1'b0;
            if (restart) begin
              sr     <= '0;
              bitcnt <= '0;
              state  <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_COMMIT: begin
          wr_stb     <= 1'b1;
          wr_addr    <= f_addr;
          wr_data    <= f_data;
          if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
          start_pend <= 1'b0;
          if (restart) begin
            sr     <= '0;
            bitcnt <= '0;
            state  <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LUPA_SHADOW_EN
  logic [NREG*DW-1:0] shadow_q;
  logic [NREG-1:0]    pend_q;
  logic               fv_s3, fv_fall;

  assign fv_fall = !fv_s2 && fv_s3;

  // A commit while Frame_Valid is low (including the falling-edge cycle) goes straight to the active bank.
  always_ff @(posedge iCLOCK_80 or negedge RST_N) begin
    if (!RST_N) begin
      fv_s3     <= 1'b0;
      shadow_q  <= DEFAULTS;
      pend_q    <= '0;
      regs_flat <= DEFAULTS;
    end else begin
      fv_s3 <= fv_s2;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (hit[i]) shadow_q[i*DW +: DW] <= f_data;
        if (!fv_s2 && hit[i])
          regs_flat[i*DW +: DW] <= f_data;
        else if (fv_fall && pend_q[i])
          regs_flat[i*DW +: DW] <= shadow_q[i*DW +: DW];
      end
      if (fv_fall)
        pend_q <= '0;
      else if (fv_s2)
        pend_q <= pend_q | hit;
    end
  end
`else
  logic unused_fv;
  assign unused_fv = fv_s2;

  always_ff @(posedge iCLOCK_80 or negedge RST_N) begin
    if (!RST_N) begin
      regs_flat <= DEFAULTS;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (hit[i]) regs_flat[i*DW +: DW] <= f_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lupa_spi_slave_regs.sv
// Directed bench for lupa_spi_slave_regs: SPI frames at 10 MHz, scoreboard of expected commits.
module tb_lupa_spi_slave_regs;

  localparam int unsigned NREG = 16;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 7;

  logic               iCLOCK_80 = 1'b0;
  logic               RST_N, SPI_EN, SPI_CLK, SPI_DAT, Frame_Valid;
  logic [NREG*DW-1:0] regs_flat;
  logic               wr_stb, frame_err;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [15:0]        wr_count;

  lupa_spi_slave_regs #(.NREG(NREG), .DW(DW), .AW(AW), .DEFAULTS('0)) dut (
    .iCLOCK_80  (iCLOCK_80),
    .RST_N      (RST_N),
    .SPI_EN     (SPI_EN),
    .SPI_CLK    (SPI_CLK),
    .SPI_DAT    (SPI_DAT),
    .Frame_Valid(Frame_Valid),
    .regs_flat  (regs_flat),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_err  (frame_err),
    .wr_count   (wr_count)
  );

  always #5 iCLOCK_80 = ~iCLOCK_80;

  int tests = 0;
  int fails = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  logic [AW+DW-1:0]   sb_q[$];
  logic [NREG*DW-1:0] exp_bank;
  logic [15:0]        exp_count;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge iCLOCK_80) begin
    #1;
    if (wr_stb) begin
      stb_cnt++;
      chk("sb_has_entry", 128'(sb_q.size() > 0), 128'(1));
      if (sb_q.size() > 0) begin
        logic [AW+DW-1:0] e;
        e = sb_q.pop_front();
        chk("wr_addr_data", 128'({wr_addr, wr_data}), 128'(e));
      end
    end
    if (frame_err) err_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iCLOCK_80);
  endtask

  task automatic spi_start();
    @(negedge iCLOCK_80);
    SPI_EN = 1'b0;
    wait_cyc(4);
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SPI_DAT = v[i];
      wait_cyc(4);
      SPI_CLK = 1'b1;
      wait_cyc(4);
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic spi_stop();
    wait_cyc(4);
    SPI_EN = 1'b1;
  endtask

  task automatic expect_write(input logic [15:0] f);
    sb_q.push_back(f[14:0]);
    exp_bank[f[14:8]*DW +: DW] = f[7:0];
    exp_count++;
  endtask

  task automatic wait_stb(output int lat);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge iCLOCK_80);
      #1;
      if (wr_stb) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, e0, s0;
    RST_N = 1'b0; SPI_EN = 1'b1; SPI_CLK = 1'b0; SPI_DAT = 1'b0; Frame_Valid = 1'b0;
    exp_bank = '0;
    exp_count = '0;
    wait_cyc(5);
    RST_N = 1'b1;
    wait_cyc(10);
    chk("reset_bank", 128'(regs_flat), 128'(exp_bank));
    chk("reset_count", 128'(wr_count), 128'(0));
    chk("reset_no_stb", 128'(stb_cnt), 128'(0));
    chk("reset_no_err", 128'(err_cnt), 128'(0));

    // valid write, latency from SPI_EN rise
    spi_start(); spi_bits(32'h8A5C, 16); expect_write(16'h8A5C); spi_stop();
    wait_stb(lat);
    chk("latency", 128'(lat), 128'(5));
    chk("wr_addr10", 128'(wr_addr), 128'(10));
    chk("wr_data5c", 128'(wr_data), 128'(8'h5C));
    chk("reg10", 128'(regs_flat[10*DW +: DW]), 128'(8'h5C));
    chk("count1", 128'(wr_count), 128'(exp_count));
    wait_cyc(10);

    // short and long frames
    e0 = err_cnt; s0 = stb_cnt;
    spi_start(); spi_bits(32'h0000_4A5C, 15); spi_stop(); wait_cyc(12);
    spi_start(); spi_bits(32'h0001_14B9, 17); spi_stop(); wait_cyc(12);
    chk("len_err_x2", 128'(err_cnt - e0), 128'(2));
    chk("len_no_stb", 128'(stb_cnt - s0), 128'(0));
    chk("len_bank", 128'(regs_flat), 128'(exp_bank));
    chk("len_count", 128'(wr_count), 128'(exp_count));

    // out-of-range write, then a read frame
    e0 = err_cnt; s0 = stb_cnt;
    spi_start(); spi_bits(32'h9011, 16); spi_stop(); wait_cyc(12);
    chk("oor_err", 128'(err_cnt - e0), 128'(1));
    spi_start(); spi_bits(32'h0A00, 16); spi_stop(); wait_cyc(12);
    chk("read_no_err", 128'(err_cnt - e0), 128'(1));
    chk("read_no_stb", 128'(stb_cnt - s0), 128'(0));
    chk("read_bank", 128'(regs_flat), 128'(exp_bank));

    // reset mid-frame, then a full frame
    spi_start(); spi_bits(32'hFF, 8);
    RST_N = 1'b0; SPI_EN = 1'b1;
    exp_bank = '0; exp_count = '0;
    wait_cyc(4);
    chk("midrst_bank", 128'(regs_flat), 128'(0));
    chk("midrst_count", 128'(wr_count), 128'(0));
    RST_N = 1'b1;
    wait_cyc(6);
    e0 = err_cnt;
    spi_start(); spi_bits(32'h8301, 16); expect_write(16'h8301); spi_stop(); wait_cyc(12);
    chk("postrst_bank", 128'(regs_flat), 128'(exp_bank));
    chk("postrst_count", 128'(wr_count), 128'(1));
    chk("postrst_no_err", 128'(err_cnt - e0), 128'(0));

    // back-to-back frames: next SPI_EN fall lands during CHECK/COMMIT
    e0 = err_cnt; s0 = stb_cnt;
    spi_start(); spi_bits(32'h8155, 16); expect_write(16'h8155); spi_stop();
    wait_cyc(2);
    spi_start(); spi_bits(32'h84AA, 16); expect_write(16'h84AA); spi_stop();
    wait_cyc(12);
    chk("b2b_stb", 128'(stb_cnt - s0), 128'(2));
    chk("b2b_no_err", 128'(err_cnt - e0), 128'(0));
    chk("b2b_bank", 128'(regs_flat), 128'(exp_bank));
    chk("b2b_count", 128'(wr_count), 128'(exp_count));

    // write while Frame_Valid is high
    Frame_Valid = 1'b1;
    wait_cyc(5);
    spi_start(); spi_bits(32'h8207, 16); expect_write(16'h8207); spi_stop();
    wait_stb(lat);
    chk("fv_stb_latency", 128'(lat), 128'(5));
    chk("fv_count", 128'(wr_count), 128'(exp_count));
`ifdef LUPA_SHADOW_EN
    chk("shadow_hold_at_stb", 128'(regs_flat[2*DW +: DW]), 128'(0));
    wait_cyc(6);
    chk("shadow_hold_later", 128'(regs_flat[2*DW +: DW]), 128'(0));
    Frame_Valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge iCLOCK_80);
      #1;
      if (regs_flat[2*DW +: DW] === 8'h07) begin
        lat = k;
        break;
      end
    end
    chk("shadow_applied_within3", 128'(lat != 0), 128'(1));
`else
    chk("reg2_at_stb", 128'(regs_flat[2*DW +: DW]), 128'(8'h07));
    Frame_Valid = 1'b0;
`endif
    wait_cyc(8);
    chk("final_bank", 128'(regs_flat), 128'(exp_bank));
    chk("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
